// File: rtl/fault.sv
// Stuck-at fault exercise circuit: x = (a XNOR b) & (~c | d), built from the
// fault-site nets u, w, p, y, with a 9-bit capture/shift observation chain.
module fault #(
  parameter int unsigned CHAIN_LEN = 9
) (
  input  logic clk,
  input  logic rst_n,
  input  logic a,
  input  logic b,
  input  logic c,
  input  logic d,
  output logic x,
  input  logic scan_en,
  input  logic capture,
  input  logic scan_in,
  output logic scan_out
);

  // Gate-level netlist kept as discrete nets so each one stays a fault site.
  logic u;
  logic w;
  logic p;
  logic y;

  assign u = a & b;
  assign w = ~(a | b);
  assign p = u | w;
  assign y = ~c | d;
  assign x = p & y;

  logic [CHAIN_LEN-1:0] chain;
  logic [CHAIN_LEN-1:0] capture_map;

  assign capture_map = {a, b, c, d, u, w, p, y, x};

  // Shift takes priority over capture; the chain only observes, never feeds x.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain <= '0;
    end else if (scan_en) begin
      chain <= {chain[CHAIN_LEN-2:0], scan_in};
    end else if (capture) begin
      chain <= capture_map;
    end
  end

  assign scan_out = chain[CHAIN_LEN-1];

endmodule

// File: tb/tb_fault.sv
// Self-checking bench for fault: truth table, scan capture/shift/hold, async
// reset, randomized traffic against a behavioural model, and stuck-at forcing.
module tb_fault;

  logic clk = 1'b0;
  logic rst_n;
  logic a, b, c, d;
  logic x;
  logic scan_en, capture, scan_in;
  logic scan_out;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  logic [8:0]  model;

  fault dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .a        (a),
    .b        (b),
    .c        (c),
    .d        (d),
    .x        (x),
    .scan_en  (scan_en),
    .capture  (capture),
    .scan_in  (scan_in),
    .scan_out (scan_out)
  );

  always #5 clk = ~clk;

  // x is 1 when a equals b, unless c is set while d is clear.
  function automatic logic ref_x(input logic [3:0] v);
    return (v[3] == v[2]) && !(v[1] && !v[0]);
  endfunction

  function automatic logic [8:0] ref_capture(input logic [3:0] v);
    logic va, vb, vc, vd;
    {va, vb, vc, vd} = v;
    return {v, va & vb, !(va | vb), va == vb, !vc | vd, ref_x(v)};
  endfunction

  task automatic check(input string tag, input logic [8:0] got, input logic [8:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  task automatic set_in(input logic [3:0] v);
    {a, b, c, d} = v;
  endtask

  task automatic cycle(input logic se, input logic cap, input logic si);
    scan_en = se;
    capture = cap;
    scan_in = si;
    @(posedge clk);
    if (rst_n) begin
      if (se)       model = {model[7:0], si};
      else if (cap) model = ref_capture({a, b, c, d});
    end
    #1;
    check("scan_out", 9'(scan_out), 9'(model[8]));
  endtask

  task automatic unload(input string tag, input logic [8:0] exp);
    for (int i = 8; i >= 0; i--) begin
      check(tag, 9'(scan_out), 9'(exp[i]));
      cycle(1'b1, 1'b0, 1'b0);
    end
  endtask

  task automatic stuck(input int unsigned site, input logic val, input string tag);
    logic [3:0] vecs [10];
    int unsigned mism;
    vecs = '{4'b0001, 4'b1101, 4'b0000, 4'b1100, 4'b0011,
             4'b1111, 4'b1001, 4'b0101, 4'b0010, 4'b1110};
    mism = 0;
    case ({site[1:0], val})
      3'b000: force dut.u = 1'b0;
      3'b001: force dut.u = 1'b1;
      3'b010: force dut.w = 1'b0;
      3'b011: force dut.w = 1'b1;
      3'b100: force dut.p = 1'b0;
      3'b101: force dut.p = 1'b1;
      3'b110: force dut.y = 1'b0;
      default: force dut.y = 1'b1;
    endcase
    for (int i = 0; i < 10; i++) begin
      set_in(vecs[i]);
      #1;
      if (x !== ref_x(vecs[i])) mism++;
    end
    release dut.u;
    release dut.w;
    release dut.p;
    release dut.y;
    #1;
    check(tag, 9'(mism != 0), 9'd1);
  endtask

  initial begin
    logic [3:0] dir_vec [10];
    logic       dir_exp [10];
    logic [8:0] pat;
    logic [3:0] v;
    int unsigned mism;

    rst_n = 1'b0;
    scan_en = 1'b0; capture = 1'b0; scan_in = 1'b0;
    set_in(4'b0000);
    model = '0;
    #1;
    check("reset_scan_out", 9'(scan_out), 9'd0);
    #1;
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      v = 4'(i);
      set_in(v);
      #1;
      check("x_all", 9'(x), 9'(ref_x(v)));
    end

    dir_vec = '{4'b0001, 4'b1101, 4'b1001, 4'b0010, 4'b1110,
                4'b0000, 4'b0011, 4'b1100, 4'b1111, 4'b0101};
    dir_exp = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 10; i++) begin
      set_in(dir_vec[i]);
      #1;
      check("x_directed", 9'(x), 9'(dir_exp[i]));
    end

    set_in(4'b1101);
    cycle(1'b0, 1'b1, 1'b0);
    unload("capture_1101", 9'b110110111);

    pat = 9'b101100111;
    for (int i = 8; i >= 0; i--) cycle(1'b1, 1'b0, pat[i]);
    unload("shift_pattern", pat);

    for (int i = 8; i >= 0; i--) cycle(1'b1, 1'b0, pat[i]);
    set_in(4'b0000);
    cycle(1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      set_in(4'($urandom));
      cycle(1'b0, 1'b0, 1'($urandom));
    end
    unload("shift_wins_hold", {pat[7:0], 1'b1});

    for (int i = 8; i >= 0; i--) cycle(1'b1, 1'b0, pat[i]);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0);
    check("pre_reset_scan_out", 9'(scan_out), 9'd1);
    set_in(4'b0000);
    scan_en = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_scan_out", 9'(scan_out), 9'd0);
    check("async_reset_x", 9'(x), 9'd1);
    model = '0;
    rst_n = 1'b1;
    unload("reset_chain_zero", 9'd0);

    for (int i = 0; i < 400; i++) begin
      v = 4'($urandom);
      set_in(v);
      if ($urandom_range(0, 19) == 0) begin
        rst_n = 1'b0;
        #1;
        check("rand_reset", 9'(scan_out), 9'd0);
        model = '0;
        rst_n = 1'b1;
      end
      #1;
      check("rand_x", 9'(x), 9'(ref_x(v)));
      cycle(1'($urandom), 1'($urandom), 1'($urandom));
    end

    mism = 0;
    for (int i = 0; i < 16; i++) begin
      v = 4'(i);
      set_in(v);
      #1;
      if (x !== ref_x(v)) mism++;
    end
    check("no_fault_clean", 9'(mism), 9'd0);
    stuck(0, 1'b0, "stuck_u0");
    stuck(0, 1'b1, "stuck_u1");
    stuck(1, 1'b0, "stuck_w0");
    stuck(1, 1'b1, "stuck_w1");
    stuck(2, 1'b0, "stuck_p0");
    stuck(2, 1'b1, "stuck_p1");
    stuck(3, 1'b0, "stuck_y0");
    stuck(3, 1'b1, "stuck_y1");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
